// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts byte/halfword/word CPU load and store requests into a sequence
//   of single-byte memory cycles. The multi-byte data is big-endian: the byte
//   at the request address is the most significant byte.
//
// Ports
//   CLK, RST_n        clock (rising edge), asynchronous active-low reset
//   ReqValid/ReqReady request handshake; accepted only in IDLE
//   ReqWrite          1 = store, 0 = load
//   ReqSize           00 byte, 01 halfword, 10 word, 11 illegal
//   ReqSigned         sign-extend loads when 1
//   ReqAddr           byte address of the most significant byte
//   ReqWData          right-justified store data
//   RespValid         one-cycle completion pulse
//   RespRData         load result (0 for stores and errors)
//   RespErr           request rejected (alignment, size or range)
//   MemEn/MemRW       byte memory strobe and direction (1 = write)
//   MemAddr/MemWData  byte address and write byte
//   MemRData          read byte, combinationally valid with MemAddr
module load_store_unit #(
  parameter int unsigned ADDR_LIMIT = 401
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespErr,
  output logic        MemEn,
  output logic        MemRW,
  output logic [31:0] MemAddr,
  output logic [7:0]  MemWData,
  input  logic [7:0]  MemRData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, nstate;

  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [1:0]  idx;
  logic [31:0] asm_q;

  logic [1:0]  req_last;
  logic        req_err;
  logic [32:0] req_end;
  logic [1:0]  last_idx;
  logic [1:0]  byte_sel;

  // Index of the final byte (N-1) for the incoming request.
  always_comb begin
    req_last = 2'd0;
    case (ReqSize)
      2'b01:   req_last = 2'd1;
      2'b10:   req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
  end

  // Last address computed 33 bits wide so addresses near 2^32 cannot wrap
  // back into the valid range.
  assign req_end = {1'b0, ReqAddr} + {31'd0, req_last};

  always_comb begin
    req_err = 1'b0;
    if (ReqSize == 2'b11)                          req_err = 1'b1;
    if (ReqSize == 2'b01 && ReqAddr[0])            req_err = 1'b1;
    if (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00) req_err = 1'b1;
    if (req_end >= 33'(ADDR_LIMIT))                req_err = 1'b1;
  end

  // Final byte index for the latched request.
  always_comb begin
    last_idx = 2'd0;
    case (lat_size)
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  end

  // Byte i of an N-byte access carries bits [8(N-i)-1 : 8(N-i-1)].
  assign byte_sel = last_idx - idx;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (ReqValid) nstate = req_err ? DONE : ACCESS;
      end
      ACCESS: begin
        if (idx == last_idx) nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      lat_write  <= 1'b0;
      lat_size   <= 2'd0;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_err    <= 1'b0;
      idx        <= 2'd0;
      asm_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            lat_write  <= ReqWrite;
            lat_size   <= ReqSize;
            lat_signed <= ReqSigned;
            lat_addr   <= ReqAddr;
            lat_wdata  <= ReqWData;
            lat_err    <= req_err;
            idx        <= 2'd0;
            asm_q      <= '0;
          end
        end
        ACCESS: begin
          idx <= (idx == last_idx) ? 2'd0 : idx + 2'd1;
          // First byte read is the most significant, so shift left.
          if (!lat_write) asm_q <= {asm_q[23:0], MemRData};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ReqReady  = (state == IDLE);
    RespValid = (state == DONE);
    RespErr   = (state == DONE) && lat_err;
    MemEn     = 1'b0;
    MemRW     = 1'b0;
    MemAddr   = '0;
    MemWData  = '0;
    if (state == ACCESS) begin
      MemEn   = 1'b1;
      MemRW   = lat_write;
      MemAddr = lat_addr + {30'd0, idx};
      if (lat_write) begin
        case (byte_sel)
          2'd0:    MemWData = lat_wdata[7:0];
          2'd1:    MemWData = lat_wdata[15:8];
          2'd2:    MemWData = lat_wdata[23:16];
          default: MemWData = lat_wdata[31:24];
        endcase
      end
    end
  end

  always_comb begin
    RespRData = '0;
    if (state == DONE && !lat_err && !lat_write) begin
      case (lat_size)
        2'b00:   RespRData = {{24{lat_signed & asm_q[7]}},  asm_q[7:0]};
        2'b01:   RespRData = {{16{lat_signed & asm_q[15]}}, asm_q[15:0]};
        default: RespRData = asm_q;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a 512-byte behavioural byte
//   memory attached to the Mem* port. Inputs are driven and outputs sampled
//   1 time unit after each rising clock edge.
module tb_load_store_unit;

  logic        CLK;
  logic        RST_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        RespErr;
  logic        MemEn;
  logic        MemRW;
  logic [31:0] MemAddr;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData;

  int checks = 0;
  int fails  = 0;
  int men_cycles = 0;

  logic [7:0] mem [0:511];

  load_store_unit #(.ADDR_LIMIT(401)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrite  (ReqWrite),
    .ReqSize   (ReqSize),
    .ReqSigned (ReqSigned),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .RespValid (RespValid),
    .RespRData (RespRData),
    .RespErr   (RespErr),
    .MemEn     (MemEn),
    .MemRW     (MemRW),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemRData  (MemRData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MemRData = mem[MemAddr[8:0]];

  always @(posedge CLK) begin
    if (MemEn && MemRW) mem[MemAddr[8:0]] <= MemWData;
  end

  always @(negedge CLK) begin
    if (MemEn) men_cycles = men_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issues one request and checks every cycle through to the return to IDLE.
  // n is the expected byte count; exp_err/exp_rdata are hand-computed.
  task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int n, input logic exp_err, input logic [31:0] exp_rdata);
    logic [31:0] exp_byte;
    int          men_before;
    chk("ready_before_req", {31'd0, ReqReady}, 32'd1);
    ReqValid  = 1'b1;
    ReqWrite  = wr;
    ReqSize   = size;
    ReqSigned = sgn;
    ReqAddr   = addr;
    ReqWData  = wdata;
    men_before = men_cycles;
    step();
    ReqValid  = 1'b0;
    ReqAddr   = 32'hFFFF_FFF0;
    ReqWData  = 32'hA5A5_A5A5;
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        chk("acc_memen",  {31'd0, MemEn}, 32'd1);
        chk("acc_memrw",  {31'd0, MemRW}, {31'd0, wr});
        chk("acc_addr",   MemAddr, addr + k);
        chk("acc_ready",  {31'd0, ReqReady}, 32'd0);
        chk("acc_rvalid", {31'd0, RespValid}, 32'd0);
        if (wr) begin
          exp_byte = (wdata >> (8 * (n - 1 - k))) & 32'hFF;
          chk("acc_wdata", {24'd0, MemWData}, exp_byte);
        end
        step();
      end
    end
    chk("done_rvalid", {31'd0, RespValid}, 32'd1);
    chk("done_err",    {31'd0, RespErr}, {31'd0, exp_err});
    chk("done_rdata",  RespRData, exp_rdata);
    chk("done_ready",  {31'd0, ReqReady}, 32'd0);
    chk("done_memen",  {31'd0, MemEn}, 32'd0);
    if (exp_err) chk("err_no_mem_cycle", men_cycles, men_before);
    step();
    chk("idle_rvalid", {31'd0, RespValid}, 32'd0);
    chk("idle_ready",  {31'd0, ReqReady}, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 8'h00;
    for (int a = 16'h30; a < 16'h34; a++) mem[a] = 8'hA5;
    RST_n     = 1'b0;
    ReqValid  = 1'b0;
    ReqWrite  = 1'b0;
    ReqSize   = 2'b00;
    ReqSigned = 1'b0;
    ReqAddr   = '0;
    ReqWData  = '0;
    step();
    step();

    // Reset state
    chk("rst_ready",  {31'd0, ReqReady}, 32'd1);
    chk("rst_rvalid", {31'd0, RespValid}, 32'd0);
    chk("rst_err",    {31'd0, RespErr}, 32'd0);
    chk("rst_rdata",  RespRData, 32'd0);
    chk("rst_memen",  {31'd0, MemEn}, 32'd0);
    chk("rst_memrw",  {31'd0, MemRW}, 32'd0);
    chk("rst_addr",   MemAddr, 32'd0);
    chk("rst_wdata",  {24'd0, MemWData}, 32'd0);
    #3 RST_n = 1'b1;
    step();

    // Word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 4, 1'b0, 32'd0);
    chk("mem_10", {24'd0, mem[16'h10]}, 32'h11);
    chk("mem_11", {24'd0, mem[16'h11]}, 32'h22);
    chk("mem_12", {24'd0, mem[16'h12]}, 32'h33);
    chk("mem_13", {24'd0, mem[16'h13]}, 32'h44);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 4, 1'b0, 32'h1122_3344);
    run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'd0, 4, 1'b0, 32'h1122_3344);

    // Byte store / signed and unsigned byte loads
    run_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080, 1, 1'b0, 32'd0);
    run_req(1'b0, 2'b00, 1'b1, 32'h20, 32'd0, 1, 1'b0, 32'hFFFF_FF80);
    run_req(1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 1, 1'b0, 32'h0000_0080);

    // Halfword store / loads
    run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 2, 1'b0, 32'd0);
    run_req(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 2, 1'b0, 32'hFFFF_8001);
    run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 2, 1'b0, 32'h0000_8001);

    // Word with MSB set, signed flag has no effect on words
    run_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h8000_0001, 4, 1'b0, 32'd0);
    run_req(1'b0, 2'b10, 1'b1, 32'h24, 32'd0, 4, 1'b0, 32'h8000_0001);

    // Errors: misaligned halfword, out-of-range word, illegal size, misaligned word
    run_req(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 0, 1'b1, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h190, 32'd0, 0, 1'b1, 32'd0);
    run_req(1'b0, 2'b11, 1'b0, 32'h40, 32'd0, 0, 1'b1, 32'd0);
    run_req(1'b1, 2'b10, 1'b0, 32'h42, 32'h1234_5678, 0, 1'b1, 32'd0);
    run_req(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd0, 0, 1'b1, 32'd0);

    // Range boundary: last byte valid, halfword crossing the limit rejected
    run_req(1'b1, 2'b00, 1'b0, 32'd400, 32'h0000_005A, 1, 1'b0, 32'd0);
    run_req(1'b0, 2'b00, 1'b0, 32'd400, 32'd0, 1, 1'b0, 32'h0000_005A);
    run_req(1'b0, 2'b01, 1'b0, 32'd398, 32'd0, 2, 1'b0, 32'h0000_0000);
    run_req(1'b0, 2'b01, 1'b0, 32'd400, 32'd0, 0, 1'b1, 32'd0);
    chk("mem_store_err_untouched", {24'd0, mem[16'h42]}, 32'h00);

    // Reset during the second byte of a word store
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
    ReqAddr  = 32'h30; ReqWData = 32'hDEAD_BEEF;
    step();
    ReqValid = 1'b0;
    chk("rstmid_b0_addr", MemAddr, 32'h30);
    step();
    chk("rstmid_b1_addr", MemAddr, 32'h31);
    #2 RST_n = 1'b0;
    #1;
    chk("rstmid_memen", {31'd0, MemEn}, 32'd0);
    chk("rstmid_memrw", {31'd0, MemRW}, 32'd0);
    chk("rstmid_ready", {31'd0, ReqReady}, 32'd1);
    step();
    chk("rstmid_rvalid_a", {31'd0, RespValid}, 32'd0);
    #3 RST_n = 1'b1;
    step();
    chk("rstmid_rvalid_b", {31'd0, RespValid}, 32'd0);
    chk("rstmid_mem30", {24'd0, mem[16'h30]}, 32'hDE);
    chk("rstmid_mem31", {24'd0, mem[16'h31]}, 32'hA5);
    chk("rstmid_mem32", {24'd0, mem[16'h32]}, 32'hA5);
    chk("rstmid_mem33", {24'd0, mem[16'h33]}, 32'hA5);
    run_req(1'b0, 2'b00, 1'b0, 32'h30, 32'd0, 1, 1'b0, 32'h0000_00DE);

    // ReqValid held high with ReqAddr changing every cycle
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqSigned = 1'b0;
    ReqAddr  = 32'h10; ReqWData = 32'd0;
    step();
    for (int k = 0; k < 4; k++) begin
      ReqAddr = 32'h100 + 32'(k * 4);
      chk("hold_addr",  MemAddr, 32'h10 + k);
      chk("hold_ready", {31'd0, ReqReady}, 32'd0);
      step();
    end
    ReqAddr = 32'h20;
    ReqSize = 2'b00;
    chk("hold_done_rvalid", {31'd0, RespValid}, 32'd1);
    chk("hold_done_rdata",  RespRData, 32'h1122_3344);
    chk("hold_done_ready",  {31'd0, ReqReady}, 32'd0);
    step();
    chk("hold_idle_ready", {31'd0, ReqReady}, 32'd1);
    chk("hold_idle_memen", {31'd0, MemEn}, 32'd0);
    step();
    ReqValid = 1'b0;
    chk("hold_second_addr", MemAddr, 32'h20);
    chk("hold_second_memen", {31'd0, MemEn}, 32'd1);
    step();
    chk("hold_second_rvalid", {31'd0, RespValid}, 32'd1);
    chk("hold_second_rdata",  RespRData, 32'h0000_0080);
    step();
    chk("hold_final_ready", {31'd0, ReqReady}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_LIMIT, default 401, number of addressable bytes (valid byte addresses 0..ADDR_LIMIT-1).
REQ-002 Single clock domain; reset is asynchronous and active-low.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST_n  input  1  asynchronous active-low reset.
REQ-005 ReqValid  input  1  CPU access request present.
REQ-006 ReqReady  output  1  unit can accept a request this cycle.
REQ-007 ReqWrite  input  1  1 = store, 0 = load.
REQ-008 ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 ReqSigned  input  1  load sign-extends when 1, zero-extends when 0.
REQ-010 ReqAddr  input  32  byte address of the most significant byte.
REQ-011 ReqWData  input  32  store data, right-justified.
REQ-012 RespValid  output  1  one-cycle completion pulse.
REQ-013 RespRData  output  32  load result; valid only while RespValid=1.
REQ-014 RespErr  output  1  access rejected; valid only while RespValid=1.
REQ-015 MemEn  output  1  byte-wide memory access active this cycle.
REQ-016 MemRW  output  1  1 = write byte, 0 = read byte; matches the memory's RW encoding.
REQ-017 MemAddr  output  32  byte address driven to memory.
REQ-018 MemWData  output  8  write byte.
REQ-019 MemRData  input  8  read byte; combinationally valid in the same cycle as MemAddr.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-021 In IDLE: ReqReady=1; the request is accepted on an edge with ReqValid=1, and ReqWrite, ReqSize, ReqSigned, ReqAddr and ReqWData are latched at that edge.
REQ-022 In ACCESS and DONE: ReqReady=0; ReqValid is ignored and later changes to Req* inputs have no effect.
REQ-023 Byte count N SHALL be 1, 2 or 4 for sizes 00, 01 or 10 respectively.
REQ-024 Error condition: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr+N-1 >= ADDR_LIMIT, with the sum computed 33-bit so there is no wrap-around.
REQ-025 On an error, the unit goes IDLE->DONE, issues no memory cycle, and asserts RespErr=1 with RespRData=0.
REQ-026 Otherwise, the unit goes IDLE->ACCESS, and a 2-bit index i counts 0..N-1, one byte per cycle.
REQ-027 In ACCESS: MemEn=1, MemRW=latched write, MemAddr=addr+i.
REQ-028 Bytes are big-endian: index i carries data bits [8(N-i)-1 : 8(N-i-1)].
REQ-029 Store: MemWData = the latched ReqWData byte selected by REQ-028.
REQ-030 Load: MemRData is captured into the assembly register at the rising edge ending each ACCESS cycle.
REQ-031 After byte N-1, the unit goes ACCESS->DONE.
REQ-032 In DONE: RespValid=1 for exactly one cycle, then DONE->IDLE; there is no response back-pressure.
REQ-033 Load result: the N assembled bytes are right-justified; the upper 32-8N bits equal the MSB of the assembled value if signed, else 0; a word load ignores ReqSigned.
REQ-034 Store response: RespRData=0, RespErr=0.
REQ-035 Latency: a request accepted at edge E gives RespValid high in the cycle after edge E+N, or after edge E+0 for an error.
REQ-036 Throughput: the next request can be accepted at the edge that ends DONE + 1 cycle, i.e. in IDLE only.
REQ-037 Outside ACCESS: MemEn=0, MemRW=0, MemAddr=0, MemWData=0, so no spurious writes occur.

Reset
REQ-038 While RST_n=0 (asynchronous): state=IDLE, i=0, assembly register=0, latched request=0, RespValid=0, RespErr=0, RespRData=0, MemEn=0, MemRW=0, MemAddr=0, MemWData=0, ReqReady=1.
REQ-039 Reset mid-ACCESS SHALL deassert MemEn/MemRW immediately, abandon the access without a response, and leave already-written bytes unchanged.
REQ-040 After RST_n rises, the first request SHALL be accepted on the first edge with ReqValid=1.

Verification
REQ-041 Word store addr=0x10 data=0x11223344 -> MemAddr 0x10..0x13 with MemWData 11,22,33,44 on 4 consecutive cycles at MemRW=1; RespValid 1 cycle later, RespErr=0.
REQ-042 Word load at 0x10 (after REQ-041) -> RespRData=0x11223344 at 5 cycles after accept.
REQ-043 Byte store 0x80 at 0x20, then byte load signed -> RespRData=0xFFFFFF80; byte load unsigned -> 0x00000080.
REQ-044 Halfword load at 0x11 (misaligned) -> RespErr=1, RespRData=0, MemEn never asserted, RespValid one cycle after accept; word load at 0x190 (400) -> RespErr=1 (out of range); ReqSize=11 -> RespErr=1.
REQ-045 RST_n pulsed low during the 2nd byte of a word store to 0x30 -> MemEn drops immediately, no RespValid, memory 0x30 written, 0x32/0x33 unchanged; the next request after reset completes normally.
REQ-046 ReqValid held high continuously with changing ReqAddr -> only addresses sampled in IDLE are accessed; ReqReady=0 throughout ACCESS/DONE.
